// File: rtl/coeff_fifo_pkg.sv
// Shared types and constants for the coefficient replay FIFO.
//   state_e          : control FSM states (IDLE / FILL / ARMED)
//   DEFAULT_SENTINEL : default set-terminator word (single-precision NaN)
//   ptr_w()          : pointer width, one wrap bit above the RAM address
package coeff_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_SENTINEL = 32'h7F90_0000;

  function automatic int unsigned ptr_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/coeff_fifo_ram.sv
// Simple dual-port RAM, synchronous read with one cycle of latency.
// The read register only updates on rd_en_i, so it holds its last word.
//   clk_i, rst_i         : clock, synchronous active-high reset (read register only)
//   wr_en_i/addr/data    : write port
//   rd_en_i/rd_addr_i    : read port
//   rd_data_o            : registered read data
module coeff_fifo_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_d, rd_data_q;

  // Storage array; contents are deliberately not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register: new word on an enabled read, otherwise hold.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      rd_data_d = mem_q[rd_addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/coeff_replay_fifo.sv
// Coefficient replay FIFO: buffers one sentinel-framed coefficient set in a
// circular RAM, lets it be replayed any number of times (redo) and freed
// explicitly (release) while the next set is already being written.
// Optional build macro COEFF_FIFO_PARITY_EN adds an even-parity bit per RAM
// word and a sticky parity error flag; without it par_err_o is tied low.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   wr_en_i, data_i     : write request / data; wr_ready_o = accepted
//   rd_en_i             : read request (framed set only)
//   redo_i, release_i   : rewind to set start / free the framed set
//   data_o, valid_o, last_o : registered read data, new-word strobe, last-of-set
//   start_o             : one-cycle pulse when a set becomes framed
//   armed_o, full_o, empty_o, used_o, set_len_o : status
//   par_err_o           : sticky parity error
module coeff_replay_fifo
  import coeff_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_W   = 4,
  parameter logic [31:0] SENTINEL = DEFAULT_SENTINEL
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [WIDTH-1:0]  data_i,
  output logic              wr_ready_o,
  input  logic              rd_en_i,
  input  logic              redo_i,
  input  logic              release_i,
  output logic [WIDTH-1:0]  data_o,
  output logic              valid_o,
  output logic              last_o,
  output logic              start_o,
  output logic              armed_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   used_o,
  output logic [ADDR_W:0]   set_len_o,
  output logic              par_err_o
);

  localparam int unsigned PTR_W = ptr_w(ADDR_W);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef COEFF_FIFO_PARITY_EN
  localparam int unsigned RAM_W = WIDTH + 1;
`else
  localparam int unsigned RAM_W = WIDTH;
`endif
  localparam logic [WIDTH-1:0] SENT_W = WIDTH'(SENTINEL);

  state_e             state_d, state_q;
  logic [PTR_W-1:0]   wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_d, rd_ptr_q;
  logic [PTR_W-1:0]   set_base_d, set_base_q;
  logic [PTR_W-1:0]   set_end_d, set_end_q;
  logic [PTR_W-1:0]   set_len_d, set_len_q;
  logic               start_d, start_q;
  logic               valid_d, valid_q;
  logic               last_d, last_q;

  logic [PTR_W-1:0]   used_c;
  logic               full_c;
  logic               is_sent_c;
  logic               wr_ready_c;
  logic               wr_store_c;
  logic               wr_frame_c;
  logic               rd_acc_c;
  logic [RAM_W-1:0]   ram_wdata_c;
  logic [RAM_W-1:0]   ram_rdata;

  // Occupancy is measured from the framed set's base so replayed words stay counted.
  assign used_c     = PTR_W'(wr_ptr_q - set_base_q);
  assign full_c     = (used_c == PTR_W'(DEPTH));
  assign is_sent_c  = (data_i == SENT_W);
  // A second sentinel cannot be taken while a set is still framed.
  assign wr_ready_c = !full_c && !((state_q == ARMED) && is_sent_c);
  assign wr_store_c = wr_en_i && wr_ready_c && !is_sent_c;
  assign wr_frame_c = wr_en_i && wr_ready_c && is_sent_c;
  assign rd_acc_c   = (state_q == ARMED) && rd_en_i && !redo_i && !release_i
                      && (rd_ptr_q != set_end_q);

  // Next-state, pointer and output logic.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    set_base_d = set_base_q;
    set_end_d  = set_end_q;
    set_len_d  = set_len_q;
    start_d    = 1'b0;
    valid_d    = 1'b0;
    last_d     = 1'b0;

    if (wr_store_c) begin
      wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
      if (state_q == IDLE) begin
        state_d = FILL;
      end
    end

    // Sentinels only land outside ARMED, so framing never collides with release.
    if (wr_frame_c) begin
      set_end_d = wr_ptr_q;
      set_len_d = PTR_W'(wr_ptr_q - set_base_q);
      rd_ptr_d  = set_base_q;
      start_d   = 1'b1;
      state_d   = ARMED;
    end

    if (state_q == ARMED) begin
      if (release_i) begin
        set_base_d = set_end_q;
        set_len_d  = '0;
        rd_ptr_d   = set_end_q;
        // Words written behind the set (including this cycle's) keep us in FILL.
        state_d    = (wr_ptr_d != set_end_q) ? FILL : IDLE;
      end else if (redo_i) begin
        rd_ptr_d = set_base_q;
      end else if (rd_acc_c) begin
        rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
        valid_d  = 1'b1;
        last_d   = (PTR_W'(rd_ptr_q + PTR_W'(1)) == set_end_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      set_base_q <= '0;
      set_end_q  <= '0;
      set_len_q  <= '0;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      set_base_q <= set_base_d;
      set_end_q  <= set_end_d;
      set_len_q  <= set_len_d;
      start_q    <= start_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

`ifdef COEFF_FIFO_PARITY_EN
  logic par_hit_c;
  logic par_err_d, par_err_q;

  // Even parity in the top bit: a clean word XORs to zero.
  assign ram_wdata_c = {^data_i, data_i};
  assign par_hit_c   = valid_q && (^ram_rdata);

  always_comb begin
    par_err_d = par_err_q | par_hit_c;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  // Flag rises with the offending word's valid_o, then holds.
  assign par_err_o = par_err_q | par_hit_c;
`else
  assign ram_wdata_c = data_i;
  assign par_err_o   = 1'b0;
`endif

  coeff_fifo_ram #(
    .DATA_W (RAM_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_store_c),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i (ram_wdata_c),
    .rd_en_i   (rd_acc_c),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (ram_rdata)
  );

  assign wr_ready_o = wr_ready_c;
  assign data_o     = ram_rdata[WIDTH-1:0];
  assign valid_o    = valid_q;
  assign last_o     = last_q;
  assign start_o    = start_q;
  assign armed_o    = (state_q == ARMED);
  assign full_o     = full_c;
  assign empty_o    = (used_c == '0);
  assign used_o     = used_c;
  assign set_len_o  = set_len_q;

endmodule

// File: tb/tb_coeff_replay_fifo.sv
// Self-checking bench for coeff_replay_fifo (DEPTH = 4 to reach full quickly).
module tb_coeff_replay_fifo;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] SENT   = 32'h7F90_0000;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              wr_en_i = 1'b0;
  logic [WIDTH-1:0]  data_i = '0;
  logic              wr_ready_o;
  logic              rd_en_i = 1'b0;
  logic              redo_i = 1'b0;
  logic              release_i = 1'b0;
  logic [WIDTH-1:0]  data_o;
  logic              valid_o, last_o, start_o, armed_o, full_o, empty_o, par_err_o;
  logic [ADDR_W:0]   used_o, set_len_o;

  always #5 clk = ~clk;

  coeff_replay_fifo #(
    .WIDTH (WIDTH), .ADDR_W (ADDR_W), .SENTINEL (SENT)
  ) dut (
    .clk_i (clk), .rst_i (rst_i), .wr_en_i (wr_en_i), .data_i (data_i),
    .wr_ready_o (wr_ready_o), .rd_en_i (rd_en_i), .redo_i (redo_i),
    .release_i (release_i), .data_o (data_o), .valid_o (valid_o),
    .last_o (last_o), .start_o (start_o), .armed_o (armed_o),
    .full_o (full_o), .empty_o (empty_o), .used_o (used_o),
    .set_len_o (set_len_o), .par_err_o (par_err_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_mem[$];
  int          m_len = 0;
  int          m_rd = 0;
  bit          m_armed = 0;

  int tests_run = 0;
  int tests_failed = 0;

  // Scoreboard: every valid_o word must match the oldest expected read.
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_valid: data_o=%h, expected no read", data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (data_o !== e.data || last_o !== e.last) begin
          tests_failed++;
          $display("FAIL read_data: got data=%h last=%b, expected data=%h last=%b",
                   data_o, last_o, e.data, e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle; the reference queue model predicts reads and occupancy.
  task automatic drive_cycle(input logic w, input logic [31:0] d, input logic r,
                             input logic rd, input logic rl, output logic rdy);
    bit exp_rdy;
    wr_en_i = w; data_i = d; rd_en_i = r; redo_i = rd; release_i = rl;
    #1;
    rdy = wr_ready_o;
    exp_rdy = (m_mem.size() < DEPTH) && !(m_armed && d == SENT);
    if (m_armed && rl) begin
      for (int i = 0; i < m_len; i++) void'(m_mem.pop_front());
      m_len = 0; m_rd = 0; m_armed = 0;
    end else if (m_armed && rd) begin
      m_rd = 0;
    end else if (m_armed && r && m_rd < m_len) begin
      exp_t e;
      e.data = m_mem[m_rd];
      e.last = (m_rd + 1 == m_len);
      exp_q.push_back(e);
      m_rd++;
    end
    if (w && exp_rdy) begin
      if (d != SENT) m_mem.push_back(d);
      else begin m_len = m_mem.size(); m_armed = 1; m_rd = 0; end
    end
    tick();
    wr_en_i = 0; data_i = '0; rd_en_i = 0; redo_i = 0; release_i = 0;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    m_mem.delete(); m_len = 0; m_rd = 0; m_armed = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run += 6;
    if (valid_o !== 1'b0 || last_o !== 1'b0 || start_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_strobes: valid=%b last=%b start=%b, expected 0", valid_o, last_o, start_o);
    end
    if (armed_o !== 1'b0 || full_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags: armed=%b full=%b, expected 0", armed_o, full_o);
    end
    if (empty_o !== 1'b1) begin
      tests_failed++; $display("FAIL reset_empty: got %b, expected 1", empty_o);
    end
    if (used_o !== 3'd0 || set_len_o !== 3'd0) begin
      tests_failed++; $display("FAIL reset_counts: used=%0d set_len=%0d, expected 0", used_o, set_len_o);
    end
    if (data_o !== 32'h0) begin
      tests_failed++; $display("FAIL reset_data: got %h, expected 0", data_o);
    end
    if (par_err_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_par_err: got %b, expected 0", par_err_o);
    end
  endtask

  task automatic test_framing();
    logic rdy;
    logic [31:0] words [3];
    words[0] = 32'h3F80_0000; words[1] = 32'h4000_0000; words[2] = 32'h4040_0000;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, words[i], 0, 0, 0, rdy);
      tests_run++;
      if (rdy !== 1'b1) begin
        tests_failed++; $display("FAIL frame_wr_ready[%0d]: got %b, expected 1", i, rdy);
      end
    end
    tests_run++;
    if (start_o !== 1'b0 || armed_o !== 1'b0) begin
      tests_failed++; $display("FAIL frame_pre_sentinel: start=%b armed=%b, expected 0 0", start_o, armed_o);
    end
    drive_cycle(1, SENT, 0, 0, 0, rdy);
    tests_run += 3;
    if (start_o !== 1'b1 || armed_o !== 1'b1) begin
      tests_failed++; $display("FAIL frame_start_armed: start=%b armed=%b, expected 1 1", start_o, armed_o);
    end
    if (set_len_o !== 3'd3 || used_o !== 3'd3) begin
      tests_failed++; $display("FAIL frame_len_used: set_len=%0d used=%0d, expected 3 3", set_len_o, used_o);
    end
    tick();
    if (start_o !== 1'b0) begin
      tests_failed++; $display("FAIL frame_start_pulse: got %b one cycle later, expected 0", start_o);
    end
  endtask

  task automatic test_replay();
    logic rdy;
    for (int i = 0; i < 3; i++) drive_cycle(0, '0, 1, 0, 0, rdy);
    drive_cycle(0, '0, 0, 1, 0, rdy);
    for (int i = 0; i < 3; i++) drive_cycle(0, '0, 1, 0, 0, rdy);
    drive_cycle(0, '0, 1, 0, 0, rdy);
    tests_run += 4;
    if (valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL replay_past_end: valid=%b, expected 0", valid_o);
    end
    if (data_o !== 32'h4040_0000) begin
      tests_failed++; $display("FAIL replay_data_hold: got %h, expected 40400000", data_o);
    end
    if (used_o !== 3'd3) begin
      tests_failed++; $display("FAIL replay_used: got %0d, expected 3", used_o);
    end
    if (par_err_o !== 1'b0) begin
      tests_failed++; $display("FAIL replay_par_err: got %b, expected 0", par_err_o);
    end
  endtask

  task automatic test_full_overlap();
    logic rdy;
    drive_cycle(1, 32'h1111_1111, 0, 0, 0, rdy);
    tests_run += 2;
    if (rdy !== 1'b1) begin
      tests_failed++; $display("FAIL overlap_wr_ready: got %b, expected 1", rdy);
    end
    if (full_o !== 1'b1 || used_o !== 3'd4) begin
      tests_failed++; $display("FAIL full_flag: full=%b used=%0d, expected 1 4", full_o, used_o);
    end
    drive_cycle(1, 32'h2222_2222, 0, 0, 0, rdy);
    tests_run++;
    if (rdy !== 1'b0 || used_o !== 3'd4) begin
      tests_failed++; $display("FAIL full_refuse: ready=%b used=%0d, expected 0 4", rdy, used_o);
    end
    drive_cycle(0, '0, 0, 0, 1, rdy);
    tests_run += 2;
    if (used_o !== 3'd1 || full_o !== 1'b0 || set_len_o !== 3'd0) begin
      tests_failed++; $display("FAIL release_counts: used=%0d full=%b set_len=%0d, expected 1 0 0", used_o, full_o, set_len_o);
    end
    if (armed_o !== 1'b0 || empty_o !== 1'b0) begin
      tests_failed++; $display("FAIL release_state: armed=%b empty=%b, expected 0 0", armed_o, empty_o);
    end
    drive_cycle(1, SENT, 0, 0, 0, rdy);
    tests_run++;
    if (armed_o !== 1'b1 || set_len_o !== 3'd1) begin
      tests_failed++; $display("FAIL reframe: armed=%b set_len=%0d, expected 1 1", armed_o, set_len_o);
    end
    drive_cycle(0, '0, 1, 0, 0, rdy);
  endtask

  task automatic test_priority();
    logic rdy;
    drive_cycle(1, 32'hAAAA_0001, 0, 0, 0, rdy);
    drive_cycle(1, 32'hAAAA_0002, 0, 0, 0, rdy);
    drive_cycle(0, '0, 1, 1, 0, rdy);
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL redo_beats_read: valid=%b, expected 0", valid_o);
    end
    drive_cycle(0, '0, 1, 0, 0, rdy);
    drive_cycle(0, '0, 0, 1, 1, rdy);
    tests_run += 2;
    if (armed_o !== 1'b0) begin
      tests_failed++; $display("FAIL release_beats_redo: armed=%b, expected 0", armed_o);
    end
    if (used_o !== 3'd2) begin
      tests_failed++; $display("FAIL release_used: got %0d, expected 2", used_o);
    end
  endtask

  task automatic test_sentinel_refusal();
    logic rdy;
    drive_cycle(1, SENT, 0, 0, 0, rdy);
    drive_cycle(0, '0, 1, 0, 0, rdy);
    drive_cycle(0, '0, 1, 0, 0, rdy);
    drive_cycle(1, SENT, 0, 0, 0, rdy);
    tests_run++;
    if (rdy !== 1'b0 || used_o !== 3'd2 || set_len_o !== 3'd2) begin
      tests_failed++; $display("FAIL armed_sentinel: ready=%b used=%0d set_len=%0d, expected 0 2 2", rdy, used_o, set_len_o);
    end
    drive_cycle(1, SENT, 0, 0, 1, rdy);
    tests_run++;
    if (rdy !== 1'b0 || armed_o !== 1'b0 || empty_o !== 1'b1) begin
      tests_failed++; $display("FAIL release_sentinel: ready=%b armed=%b empty=%b, expected 0 0 1", rdy, armed_o, empty_o);
    end
    drive_cycle(1, SENT, 0, 0, 0, rdy);
    tests_run++;
    if (rdy !== 1'b1 || armed_o !== 1'b1 || set_len_o !== 3'd0 || start_o !== 1'b1 || empty_o !== 1'b1) begin
      tests_failed++; $display("FAIL zero_len_set: ready=%b armed=%b set_len=%0d start=%b empty=%b, expected 1 1 0 1 1",
                               rdy, armed_o, set_len_o, start_o, empty_o);
    end
    drive_cycle(0, '0, 1, 0, 0, rdy);
    drive_cycle(0, '0, 1, 0, 0, rdy);
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL zero_len_read: valid=%b, expected 0", valid_o);
    end
    drive_cycle(0, '0, 0, 0, 1, rdy);
    tests_run++;
    if (armed_o !== 1'b0 || empty_o !== 1'b1) begin
      tests_failed++; $display("FAIL zero_len_release: armed=%b empty=%b, expected 0 1", armed_o, empty_o);
    end
  endtask

  task automatic test_reset_mid_read();
    logic rdy;
    drive_cycle(1, 32'h4080_0000, 0, 0, 0, rdy);
    drive_cycle(1, 32'h40A0_0000, 0, 0, 0, rdy);
    drive_cycle(1, 32'h40C0_0000, 0, 0, 0, rdy);
    drive_cycle(1, SENT, 0, 0, 0, rdy);
    drive_cycle(0, '0, 1, 0, 0, rdy);
    rst_i = 1'b1; rd_en_i = 1'b1;
    tick();
    rst_i = 1'b0; rd_en_i = 1'b0;
    m_mem.delete(); m_len = 0; m_rd = 0; m_armed = 0;
    tests_run += 2;
    if (valid_o !== 1'b0 || empty_o !== 1'b1 || used_o !== 3'd0) begin
      tests_failed++; $display("FAIL mid_read_reset: valid=%b empty=%b used=%0d, expected 0 1 0", valid_o, empty_o, used_o);
    end
    if (armed_o !== 1'b0 || data_o !== 32'h0) begin
      tests_failed++; $display("FAIL mid_read_reset_state: armed=%b data=%h, expected 0 0", armed_o, data_o);
    end
  endtask

`ifdef COEFF_FIFO_PARITY_EN
  task automatic test_parity();
    logic rdy;
    drive_cycle(1, 32'h3F80_0000, 0, 0, 0, rdy);
    drive_cycle(1, 32'h4000_0000, 0, 0, 0, rdy);
    drive_cycle(1, SENT, 0, 0, 0, rdy);
    dut.u_ram.mem_q[0][0] = ~dut.u_ram.mem_q[0][0];
    m_mem[0] = m_mem[0] ^ 32'h1;
    drive_cycle(0, '0, 1, 0, 0, rdy);
    tests_run++;
    if (par_err_o !== 1'b1) begin
      tests_failed++; $display("FAIL parity_detect: got %b, expected 1", par_err_o);
    end
    drive_cycle(0, '0, 1, 0, 0, rdy);
    tick();
    tests_run++;
    if (par_err_o !== 1'b1) begin
      tests_failed++; $display("FAIL parity_sticky: got %b, expected 1", par_err_o);
    end
    apply_reset();
    tests_run++;
    if (par_err_o !== 1'b0) begin
      tests_failed++; $display("FAIL parity_clear: got %b, expected 0", par_err_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_framing();
    test_replay();
    test_full_overlap();
    test_priority();
    test_sentinel_refusal();
    test_reset_mid_read();
`ifdef COEFF_FIFO_PARITY_EN
    test_parity();
`endif
    tick();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL scoreboard_drain: %0d expected reads never seen, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
